// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state encodings for count_ctrl and its bench
package count_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - push-button synchronizer with registered rising-edge press pulse
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Synchronize the raw button, then emit one pulse per rising edge. The
  // detector only arms once the chain holds real post-reset samples and a
  // released level has been seen, so a button held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= level;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~level);
      press   <= level & ~prev_q & armed_q;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - start/pause/clear controlled up/down counter with terminal limit
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         btn_start,
  input  logic         btn_pause,
  input  logic         btn_clr,
  input  logic         dir_up,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         cnt_en,
  output logic [1:0]   state,
  output logic         done
);

  logic         start_p;
  logic         pause_p;
  logic         clr_p;
  logic         dir_q;
  logic [W-1:0] lim_q;
  logic [W-1:0] terminal;
  logic [1:0]   state_nx;
  logic [W-1:0] count_nx;
  logic         dir_nx;
  logic [W-1:0] lim_nx;
  logic         en_nx;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .press (start_p)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .press (pause_p)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (clr_p)
  );

  assign terminal = dir_q ? lim_q : '0;

  // Next-state logic: only the highest-priority event of the cycle is acted
  // on (clear, then pause, then start, then tick); the rest are dropped.
  always_comb begin
    state_nx = state;
    count_nx = count;
    dir_nx   = dir_q;
    lim_nx   = lim_q;
    en_nx    = 1'b0;
    if (clr_p) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else if (pause_p) begin
      if (state == ST_RUN) begin
        state_nx = ST_PAUSE;
      end else if (state == ST_PAUSE) begin
        state_nx = ST_RUN;
      end
    end else if (start_p) begin
      if (state == ST_IDLE || state == ST_DONE) begin
        dir_nx   = dir_up;
        lim_nx   = limit;
        count_nx = dir_up ? '0 : limit;
        state_nx = ST_RUN;
      end else if (state == ST_PAUSE) begin
        state_nx = ST_RUN;
      end
    end else if (tick && state == ST_RUN) begin
      // Terminal compare comes first so the count never wraps.
      if (count == terminal) begin
        state_nx = ST_DONE;
      end else begin
        count_nx = dir_q ? count + W'(1) : count - W'(1);
        en_nx    = 1'b1;
      end
    end
  end

  // Register FSM, datapath and all outputs; reset also drops the latched run setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      dir_q  <= 1'b0;
      lim_q  <= '0;
      cnt_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      dir_q  <= dir_nx;
      lim_q  <= lim_nx;
      cnt_en <= en_nx;
      done   <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - randomized self-checking bench for count_ctrl
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic         btn_start;
  logic         btn_pause;
  logic         btn_clr;
  logic         dir_up;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         cnt_en;
  logic [1:0]   state;
  logic         done;

  int n_checks;
  int n_errors;
  int en_seen;

  // Reference model: pulses derived from the history of sampled button levels
  bit qs[$];
  bit qp[$];
  bit qc[$];
  int m_state;
  int m_count;
  int m_dir;
  int m_lim;
  int m_en;

  count_ctrl #(.W(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_clr   (btn_clr),
    .dir_up    (dir_up),
    .limit     (limit),
    .count     (count),
    .cnt_en    (cnt_en),
    .state     (state),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    qs.delete();
    qp.delete();
    qc.delete();
    m_state = 0;
    m_count = 0;
    m_dir   = 0;
    m_lim   = 0;
    m_en    = 0;
  endfunction

  // A press acts three edges after its first high sample, provided the
  // preceding post-reset sample was low.
  function automatic bit pulse_at(input bit q[$]);
    int e;
    e = q.size();
    if (e < 5) return 1'b0;
    return q[e-4] && !q[e-5];
  endfunction

  function automatic void model_apply(input bit pc, input bit pp, input bit ps,
                                      input bit tk, input bit d, input int lim);
    int term;
    m_en = 0;
    term = (m_dir != 0) ? m_lim : 0;
    if (pc) begin
      m_state = 0;
      m_count = 0;
    end else if (pp) begin
      if (m_state == 1) m_state = 2;
      else if (m_state == 2) m_state = 1;
    end else if (ps) begin
      if (m_state == 0 || m_state == 3) begin
        m_dir   = d;
        m_lim   = lim;
        m_count = d ? 0 : lim;
        m_state = 1;
      end else if (m_state == 2) begin
        m_state = 1;
      end
    end else if (tk && m_state == 1) begin
      if (m_count == term) begin
        m_state = 3;
      end else begin
        m_count = m_count + (m_dir != 0 ? 1 : -1);
        m_en = 1;
      end
    end
  endfunction

  task automatic step();
    bit ps;
    bit pp;
    bit pc;
    @(posedge clk);
    qs.push_back(btn_start);
    qp.push_back(btn_pause);
    qc.push_back(btn_clr);
    ps = pulse_at(qs);
    pp = pulse_at(qp);
    pc = pulse_at(qc);
    model_apply(pc, pp, ps, tick, dir_up, int'(limit));
    #1;
    if (cnt_en) en_seen++;
    check("state", int'(state), m_state);
    check("count", int'(count), m_count);
    check("cnt_en", int'(cnt_en), m_en);
    check("done", int'(done), (m_state == int'(ST_DONE)) ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int which);
    if (which == 0) btn_start = 1'b1;
    else if (which == 1) btn_pause = 1'b1;
    else btn_clr = 1'b1;
    run(2);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
    run(4);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_state"}, int'(state), int'(ST_IDLE));
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_cnt_en"}, int'(cnt_en), 0);
    check({tag, "_done"}, int'(done), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int en0;
    n_checks  = 0;
    n_errors  = 0;
    en_seen   = 0;
    rst_n     = 1'b0;
    tick      = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
    dir_up    = 1'b1;
    limit     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), int'(ST_IDLE));
    check("rst_count", int'(count), 0);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_done", int'(done), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(6);

    // Up run to limit 3
    limit = 8'd3;
    dir_up = 1'b1;
    press(0);
    check("up_load", int'(count), 0);
    limit = 8'd200;
    dir_up = 1'b0;
    en0 = en_seen;
    repeat (5) do_tick();
    check("up_count", int'(count), 3);
    check("up_done", int'(done), 1);
    check("up_en_pulses", en_seen - en0, 3);

    // Down run from 2, restarted out of DONE
    limit = 8'd2;
    dir_up = 1'b0;
    press(0);
    check("dn_load", int'(count), 2);
    repeat (3) do_tick();
    check("dn_count", int'(count), 0);
    check("dn_done", int'(done), 1);

    // Pause freezes the count
    limit = 8'd10;
    dir_up = 1'b1;
    press(0);
    repeat (4) do_tick();
    check("pz_run", int'(count), 4);
    press(1);
    repeat (3) do_tick();
    check("pz_hold", int'(count), 4);
    check("pz_state", int'(state), int'(ST_PAUSE));
    press(1);
    do_tick();
    check("pz_resume", int'(count), 5);
    do_tick();

    // Clear, pause and tick all in one cycle at count 6
    btn_clr = 1'b1;
    btn_pause = 1'b1;
    run(3);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("sim_state", int'(state), int'(ST_IDLE));
    check("sim_count", int'(count), 0);
    check("sim_cnt_en", int'(cnt_en), 0);
    btn_clr = 1'b0;
    btn_pause = 1'b0;
    run(4);

    // Held start: one pulse, RUN at the third edge after first sample
    limit = 8'd5;
    dir_up = 1'b1;
    btn_start = 1'b1;
    run(3);
    check("hold_n2", int'(state), int'(ST_IDLE));
    step();
    check("hold_n3", int'(state), int'(ST_RUN));
    run(20);
    btn_pause = 1'b1;
    run(2);
    btn_pause = 1'b0;
    run(74);
    check("hold_single", int'(state), int'(ST_PAUSE));
    btn_start = 1'b0;
    run(4);
    press(2);

    // Async reset mid-run at count 7
    limit = 8'd20;
    press(0);
    repeat (7) do_tick();
    check("ar_pre", int'(count), 7);
    async_reset("ar");
    repeat (4) do_tick();
    check("ar_ticks", int'(count), 0);
    check("ar_idle", int'(state), int'(ST_IDLE));
    press(0);
    check("ar_restart", int'(state), int'(ST_RUN));

    // Start held through reset release gives no press until re-pressed
    btn_start = 1'b1;
    async_reset("hr");
    run(10);
    check("hr_held", int'(state), int'(ST_IDLE));
    btn_start = 1'b0;
    run(6);
    check("hr_released", int'(state), int'(ST_IDLE));
    press(0);
    check("hr_pressed", int'(state), int'(ST_RUN));

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick   = ($urandom_range(2) == 0);
      dir_up = $urandom_range(1);
      limit  = ($urandom_range(9) == 0) ? W'($urandom) : W'($urandom_range(11));
      if ($urandom_range(19) == 0) btn_start = ~btn_start;
      if ($urandom_range(29) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(199) == 0) btn_clr = 1'b1;
      else if ($urandom_range(3) == 0) btn_clr = 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
